// File: rtl/kmac_pkg.sv
// -----------------------------------------------------------------------------
// kmac_pkg
//   Shared KMAC types: the error report record and codes, the multi-bit
//   encodings used on the datapath-clear and life-cycle escalation wires,
//   and the sparse state encoding of the error-report FSM.
//
//   Contents:
//     mubi4_t / MuBi4True / MuBi4False   multi-bit boolean, 4 bits
//     lc_tx_t / On / Off                 life-cycle broadcast value, 4 bits
//     lc_tx_test_true_loose()            anything other than Off counts as on
//     err_code_e                         8-bit error codes
//     err_t                              {valid, code[7:0], info[23:0]}
//     err_report_st_e                    error-report FSM states
// -----------------------------------------------------------------------------
package kmac_pkg;

    // Multi-bit boolean: only the two patterns below are meaningful.
    typedef logic [3:0] mubi4_t;
    localparam mubi4_t MuBi4True  = 4'h6;
    localparam mubi4_t MuBi4False = 4'h9;

    // Life-cycle broadcast signal.
    typedef logic [3:0] lc_tx_t;
    localparam lc_tx_t On  = 4'h5;
    localparam lc_tx_t Off = 4'hA;

    // Loose test: a corrupted encoding is treated as asserted so that a glitch
    // on the escalation wire fails safe.
    function automatic logic lc_tx_test_true_loose(input lc_tx_t val);
        return val != Off;
    endfunction

    typedef enum logic [7:0] {
        ErrNone             = 8'h00,
        ErrSwCmdSequence    = 8'h01,
        ErrKeyNotValid      = 8'h02,
        ErrSwPushedMsgFifo  = 8'h03,
        ErrWaitTimerExpired = 8'h04,
        ErrFatalError       = 8'hC1
    } err_code_e;

    typedef struct packed {
        logic        valid;
        logic [7:0]  code;
        logic [23:0] info;
    } err_t;

    // Error-report FSM. Every pair of encodings differs in at least 3 bits so
    // a single or double upset never lands on another legal state.
    localparam int ErrReportStateWidth = 6;

    typedef enum logic [ErrReportStateWidth-1:0] {
        StIdle          = 6'b000111,
        StPending       = 6'b011000,
        StClearing      = 6'b101101,
        StTerminalError = 6'b110010
    } err_report_st_e;

endpackage : kmac_pkg

// File: rtl/kmac_err_report.sv
// -----------------------------------------------------------------------------
// kmac_err_report
//   Consumes the err_t stream from the KMAC error checkers. The first error is
//   latched into the ERR_CODE image with a one-cycle interrupt event; further
//   errors are only counted until SW acknowledges. The acknowledge starts a
//   ClearCycles-long clear_after_error broadcast to the datapath, which ends
//   with a one-cycle err_processed pulse. Escalation or an upstream FSM error
//   parks the block in a terminal state that only reset leaves.
//
//   Parameters:
//     ClearCycles  cycles clear_after_error_o is MuBi4True (1..255)
//     DropCntW     width of the saturating dropped-error counter
//
//   Ports:
//     clk_i, rst_ni          clock, asynchronous active-low reset
//     error_i                error report {valid, code, info}
//     fsm_error_i            upstream sparse-FSM error (fatal)
//     lc_escalate_en_i       life-cycle escalation
//     err_processed_req_i    SW acknowledge pulse
//     err_code_o             {code, info} of the captured error
//     err_valid_o            one-cycle event on capture
//     err_pending_o          error awaiting acknowledge (held through clearing)
//     clear_after_error_o    datapath clear request (mubi4)
//     err_processed_o        one-cycle pulse in the last clearing cycle
//     drop_cnt_o             errors discarded while pending, saturating
//     fatal_o                terminal state
//     sparse_fsm_error_o     own state register holds an illegal encoding
// -----------------------------------------------------------------------------
module kmac_err_report
    import kmac_pkg::*;
#(
    parameter int unsigned ClearCycles = 4,
    parameter int unsigned DropCntW    = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  err_t                error_i,
    input  logic                fsm_error_i,
    input  lc_tx_t              lc_escalate_en_i,
    input  logic                err_processed_req_i,
    output logic [31:0]         err_code_o,
    output logic                err_valid_o,
    output logic                err_pending_o,
    output mubi4_t              clear_after_error_o,
    output logic                err_processed_o,
    output logic [DropCntW-1:0] drop_cnt_o,
    output logic                fatal_o,
    output logic                sparse_fsm_error_o
);

    // The clear counter counts down to zero, so it starts one below the window.
    localparam logic [7:0] ClearCntInit = 8'(ClearCycles - 1);

    // State is kept as a raw vector: an upset can leave it holding a value
    // that is not a member of err_report_st_e, and that case must be decoded.
    logic [ErrReportStateWidth-1:0] r_state;
    logic [ErrReportStateWidth-1:0] w_state_d;
    logic [7:0]                     r_clr_cnt;
    logic [7:0]                     w_clr_cnt_d;
    logic [DropCntW-1:0]            r_drop_cnt;
    logic [DropCntW-1:0]            w_drop_cnt_d;
    logic [31:0]                    r_err_code;
    logic [31:0]                    w_err_code_d;
    logic                           r_err_valid;
    logic                           w_err_valid_d;
    logic                           w_illegal;
    logic                           w_escalate;

    assign w_escalate = fsm_error_i | lc_tx_test_true_loose(lc_escalate_en_i);

    always_comb begin
        // NOTE: every variable gets a hold/default value before the case so
        // that no path leaves one unassigned, which would infer a latch.
        w_state_d     = r_state;
        w_clr_cnt_d   = r_clr_cnt;
        w_drop_cnt_d  = r_drop_cnt;
        w_err_code_d  = r_err_code;
        w_err_valid_d = 1'b0;
        w_illegal     = 1'b0;

        case (r_state)
            StIdle: begin
                if (error_i.valid) begin
                    w_err_code_d  = {error_i.code, error_i.info};
                    w_err_valid_d = 1'b1;
                    w_state_d     = StPending;
                end
            end

            StPending: begin
                // An error arriving with the acknowledge is still a drop.
                if (error_i.valid && (r_drop_cnt != '1)) begin
                    w_drop_cnt_d = r_drop_cnt + DropCntW'(1);
                end
                if (err_processed_req_i) begin
                    w_clr_cnt_d = ClearCntInit;
                    w_state_d   = StClearing;
                end
            end

            StClearing: begin
                // Errors here are side effects of the clear itself; ignore them.
                if (r_clr_cnt == '0) begin
                    w_drop_cnt_d = '0;
                    w_state_d    = StIdle;
                end else begin
                    w_clr_cnt_d = r_clr_cnt - 8'd1;
                end
            end

            StTerminalError: begin
                // Absorbing: everything held until reset.
            end

            default: begin
                w_illegal = 1'b1;
                w_state_d = StTerminalError;
            end
        endcase

        // Escalation beats every other transition, including a capture in
        // the same cycle.
        if (w_escalate) begin
            w_state_d     = StTerminalError;
            w_err_code_d  = r_err_code;
            w_err_valid_d = 1'b0;
            w_drop_cnt_d  = r_drop_cnt;
            w_clr_cnt_d   = r_clr_cnt;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= StIdle;
            r_clr_cnt   <= '0;
            r_drop_cnt  <= '0;
            r_err_code  <= '0;
            r_err_valid <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_clr_cnt   <= w_clr_cnt_d;
            r_drop_cnt  <= w_drop_cnt_d;
            r_err_code  <= w_err_code_d;
            r_err_valid <= w_err_valid_d;
        end
    end

    assign err_code_o          = r_err_code;
    assign err_valid_o         = r_err_valid;
    assign err_pending_o       = (r_state == StPending) || (r_state == StClearing);
    assign clear_after_error_o = (r_state == StClearing) ? MuBi4True : MuBi4False;
    assign err_processed_o     = (r_state == StClearing) && (r_clr_cnt == '0);
    assign drop_cnt_o          = r_drop_cnt;
    assign fatal_o             = (r_state == StTerminalError);
    assign sparse_fsm_error_o  = w_illegal;

    a_err_valid_single : assert property (
        @(posedge clk_i) disable iff (!rst_ni) err_valid_o |=> !err_valid_o);

    a_processed_in_clear : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        err_processed_o |-> (clear_after_error_o == MuBi4True));

    a_state_known : assert property (
        @(posedge clk_i) rst_ni |-> !$isunknown(r_state));

endmodule : kmac_err_report

// File: tb/tb_kmac_err_report.sv
// -----------------------------------------------------------------------------
// tb_kmac_err_report
//   Self-checking bench for kmac_err_report. Interrupt events and
//   err_processed pulses are predicted into queues when the stimulus is
//   driven and retired by a monitor when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_kmac_err_report;
    import kmac_pkg::*;

    localparam int unsigned ClearCycles = 4;
    localparam int unsigned DropCntW    = 8;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    err_t                error_i;
    logic                fsm_error_i;
    lc_tx_t              lc_escalate_en_i;
    logic                err_processed_req_i;
    logic [31:0]         err_code_o;
    logic                err_valid_o;
    logic                err_pending_o;
    mubi4_t              clear_after_error_o;
    logic                err_processed_o;
    logic [DropCntW-1:0] drop_cnt_o;
    logic                fatal_o;
    logic                sparse_fsm_error_o;

    kmac_err_report #(
        .ClearCycles(ClearCycles),
        .DropCntW   (DropCntW)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .error_i            (error_i),
        .fsm_error_i        (fsm_error_i),
        .lc_escalate_en_i   (lc_escalate_en_i),
        .err_processed_req_i(err_processed_req_i),
        .err_code_o         (err_code_o),
        .err_valid_o        (err_valid_o),
        .err_pending_o      (err_pending_o),
        .clear_after_error_o(clear_after_error_o),
        .err_processed_o    (err_processed_o),
        .drop_cnt_o         (drop_cnt_o),
        .fatal_o            (fatal_o),
        .sparse_fsm_error_o (sparse_fsm_error_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] code;
    } exp_valid_t;

    exp_valid_t exp_valid_q[$];
    int         exp_proc_q[$];
    exp_valid_t mon_ev;
    int         mon_pc;

    // All outputs packed together with their reset values.
    localparam logic [48:0] ResetImage = {32'h0, 1'b0, 1'b0, MuBi4False, 1'b0, 8'h0, 1'b0, 1'b0};
    wire [48:0] out_image = {err_code_o, err_valid_o, err_pending_o, clear_after_error_o,
                             err_processed_o, drop_cnt_o, fatal_o, sparse_fsm_error_o};

    // Monitor: retire predicted pulses as the DUT produces them.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1) begin
            if (err_valid_o === 1'b1) begin
                checks++;
                if (exp_valid_q.size() == 0) begin
                    errors++;
                    $display("FAIL err_valid_sb: unexpected pulse at cycle %0d code %h, want none", cyc, err_code_o);
                end else begin
                    mon_ev = exp_valid_q.pop_front();
                    if (mon_ev.cyc != cyc || mon_ev.code !== err_code_o) begin
                        errors++;
                        $display("FAIL err_valid_sb: got cycle %0d code %h, want cycle %0d code %h",
                                 cyc, err_code_o, mon_ev.cyc, mon_ev.code);
                    end
                end
            end
            if (err_processed_o === 1'b1) begin
                checks++;
                if (exp_proc_q.size() == 0) begin
                    errors++;
                    $display("FAIL err_processed_sb: unexpected pulse at cycle %0d, want none", cyc);
                end else begin
                    mon_pc = exp_proc_q.pop_front();
                    if (mon_pc != cyc) begin
                        errors++;
                        $display("FAIL err_processed_sb: got cycle %0d, want cycle %0d", cyc, mon_pc);
                    end
                end
            end
        end
    end

    // Inputs are driven and outputs compared 1 time unit after the falling edge.
    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        error_i             = '0;
        fsm_error_i         = 1'b0;
        lc_escalate_en_i    = Off;
        err_processed_req_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni = 1'b0;
        repeat (3) step();
        checks++;
        if (out_image !== ResetImage) begin
            errors++;
            $display("FAIL reset_outputs: got %h want %h", out_image, ResetImage);
        end
        rst_ni = 1'b1;
        step();
        checks++;
        if (out_image !== ResetImage) begin
            errors++;
            $display("FAIL reset_idle_outputs: got %h want %h", out_image, ResetImage);
        end
    endtask

    task automatic test_capture();
        step();
        error_i = '{valid: 1'b1, code: ErrSwCmdSequence, info: 24'h000102};
        exp_valid_q.push_back('{cyc: cyc + 1, code: 32'h01000102});
        step();
        error_i = '0;
        checks++;
        if (err_pending_o !== 1'b1 || err_code_o !== 32'h01000102) begin
            errors++;
            $display("FAIL capture: got pending %b code %h, want pending 1 code 01000102", err_pending_o, err_code_o);
        end
        step();
        checks++;
        if (err_valid_o !== 1'b0 || exp_valid_q.size() != 0) begin
            errors++;
            $display("FAIL capture_single_pulse: got valid %b outstanding %0d, want 0 and 0",
                     err_valid_o, exp_valid_q.size());
        end
    endtask

    task automatic test_drop_saturate();
        int exp_drop = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (i % 64 == 0 || (i >= 253 && i <= 257)) begin
                checks++;
                if (drop_cnt_o !== DropCntW'(exp_drop)) begin
                    errors++;
                    $display("FAIL drop_count[%0d]: got %0d want %0d", i, drop_cnt_o, exp_drop);
                end
            end
            error_i = '{valid: 1'b1, code: 8'($urandom_range(255)), info: 24'($urandom)};
            exp_drop = (exp_drop == 255) ? 255 : exp_drop + 1;
        end
        step();
        error_i = '0;
        checks++;
        if (drop_cnt_o !== 8'd255 || err_code_o !== 32'h01000102 || err_pending_o !== 1'b1) begin
            errors++;
            $display("FAIL drop_saturate: got cnt %0d code %h pending %b, want 255 01000102 1",
                     drop_cnt_o, err_code_o, err_pending_o);
        end
    endtask

    task automatic test_clear_window();
        int m;
        step();
        err_processed_req_i = 1'b1;
        m = cyc;
        exp_proc_q.push_back(m + ClearCycles);
        for (int k = 1; k <= ClearCycles; k++) begin
            step();
            // Stray errors and a repeated acknowledge land inside the window.
            error_i.valid       = (k == 1 || k == ClearCycles - 1);
            err_processed_req_i = (k == 2);
            checks++;
            if (clear_after_error_o !== MuBi4True || err_pending_o !== 1'b1) begin
                errors++;
                $display("FAIL clear_window[%0d]: got clear %h pending %b, want %h 1",
                         k, clear_after_error_o, err_pending_o, MuBi4True);
            end
            if (k == ClearCycles) begin
                checks++;
                if (drop_cnt_o !== 8'd255) begin
                    errors++;
                    $display("FAIL clear_drop_held: got %0d want 255", drop_cnt_o);
                end
            end
        end
        step();
        // First idle cycle: a new error here must be captured.
        error_i = '{valid: 1'b1, code: ErrWaitTimerExpired, info: 24'hABCDEF};
        exp_valid_q.push_back('{cyc: cyc + 1, code: 32'h04ABCDEF});
        checks++;
        if (clear_after_error_o !== MuBi4False || err_pending_o !== 1'b0 ||
            drop_cnt_o !== 8'd0 || err_processed_o !== 1'b0) begin
            errors++;
            $display("FAIL clear_done: got clear %h pending %b cnt %0d proc %b, want %h 0 0 0",
                     clear_after_error_o, err_pending_o, drop_cnt_o, err_processed_o, MuBi4False);
        end
        checks++;
        if (err_code_o !== 32'h01000102 || exp_proc_q.size() != 0) begin
            errors++;
            $display("FAIL clear_code_retained: got code %h outstanding %0d, want 01000102 0",
                     err_code_o, exp_proc_q.size());
        end
        step();
        error_i = '0;
        checks++;
        if (err_pending_o !== 1'b1 || err_code_o !== 32'h04ABCDEF) begin
            errors++;
            $display("FAIL recapture: got pending %b code %h, want 1 04ABCDEF", err_pending_o, err_code_o);
        end
    endtask

    task automatic test_back_to_back();
        int m;
        // Acknowledge and a new error in the same pending cycle.
        step();
        err_processed_req_i = 1'b1;
        error_i.valid       = 1'b1;
        m = cyc;
        exp_proc_q.push_back(m + ClearCycles);
        step();
        idle_inputs();
        checks++;
        if (drop_cnt_o !== 8'd1 || clear_after_error_o !== MuBi4True) begin
            errors++;
            $display("FAIL same_cycle_drop: got cnt %0d clear %h, want 1 %h", drop_cnt_o, clear_after_error_o, MuBi4True);
        end
        repeat (ClearCycles) step();
        checks++;
        if (err_pending_o !== 1'b0 || drop_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL back_to_back_done: got pending %b cnt %0d, want 0 0", err_pending_o, drop_cnt_o);
        end
        // Acknowledge while idle does nothing.
        err_processed_req_i = 1'b1;
        step();
        err_processed_req_i = 1'b0;
        checks++;
        if (err_pending_o !== 1'b0 || clear_after_error_o !== MuBi4False || err_processed_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack_ignored: got pending %b clear %h proc %b, want 0 %h 0",
                     err_pending_o, clear_after_error_o, err_processed_o, MuBi4False);
        end
    endtask

    task automatic test_escalation();
        logic [23:0] info = 24'($urandom);
        step();
        error_i = '{valid: 1'b1, code: ErrKeyNotValid, info: info};
        exp_valid_q.push_back('{cyc: cyc + 1, code: {8'h02, info}});
        step();
        error_i = '0;
        err_processed_req_i = 1'b1;
        step();
        err_processed_req_i = 1'b0;
        step();
        lc_escalate_en_i = On;
        step();
        lc_escalate_en_i = Off;
        checks++;
        if (fatal_o !== 1'b1 || clear_after_error_o !== MuBi4False || err_processed_o !== 1'b0) begin
            errors++;
            $display("FAIL escalate: got fatal %b clear %h proc %b, want 1 %h 0",
                     fatal_o, clear_after_error_o, err_processed_o, MuBi4False);
        end
        for (int k = 0; k < 6; k++) begin
            error_i.valid       = (k % 2 == 0);
            err_processed_req_i = (k % 2 == 1);
            step();
            checks++;
            if (fatal_o !== 1'b1 || err_code_o !== {8'h02, info} || clear_after_error_o !== MuBi4False) begin
                errors++;
                $display("FAIL terminal_hold[%0d]: got fatal %b code %h clear %h, want 1 %h %h",
                         k, fatal_o, err_code_o, clear_after_error_o, {8'h02, info}, MuBi4False);
            end
        end
        idle_inputs();
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (out_image !== ResetImage) begin
            errors++;
            $display("FAIL escalate_reset: got %h want %h", out_image, ResetImage);
        end
        step();
        rst_ni = 1'b1;
    endtask

    task automatic test_fsm_error();
        step();
        fsm_error_i = 1'b1;
        error_i     = '{valid: 1'b1, code: ErrFatalError, info: 24'h1};
        step();
        idle_inputs();
        checks++;
        if (fatal_o !== 1'b1 || err_pending_o !== 1'b0 || err_code_o !== 32'h0) begin
            errors++;
            $display("FAIL fsm_error_priority: got fatal %b pending %b code %h, want 1 0 0",
                     fatal_o, err_pending_o, err_code_o);
        end
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset_mid_clear();
        step();
        error_i = '{valid: 1'b1, code: ErrSwPushedMsgFifo, info: 24'h55AA55};
        exp_valid_q.push_back('{cyc: cyc + 1, code: 32'h0355AA55});
        step();
        error_i = '0;
        err_processed_req_i = 1'b1;
        step();
        err_processed_req_i = 1'b0;
        checks++;
        if (clear_after_error_o !== MuBi4True) begin
            errors++;
            $display("FAIL mid_clear_entry: got clear %h want %h", clear_after_error_o, MuBi4True);
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (out_image !== ResetImage) begin
            errors++;
            $display("FAIL mid_clear_reset: got %h want %h", out_image, ResetImage);
        end
        step();
        rst_ni = 1'b1;
    endtask

    task automatic test_illegal_state();
        bit seen = 1'b0;
        step();
        force dut.r_state = 6'b111111;
        #1;
        checks++;
        if (sparse_fsm_error_o !== 1'b1 || fatal_o !== 1'b0) begin
            errors++;
            $display("FAIL illegal_detect: got sparse %b fatal %b, want 1 0", sparse_fsm_error_o, fatal_o);
        end
        @(posedge clk_i);
        #1 release dut.r_state;
        for (int k = 0; k < 3 && !seen; k++) begin
            step();
            seen = (fatal_o === 1'b1);
        end
        checks++;
        if (!seen || sparse_fsm_error_o !== 1'b0) begin
            errors++;
            $display("FAIL illegal_to_terminal: got fatal %b sparse %b, want 1 0", fatal_o, sparse_fsm_error_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (out_image !== ResetImage) begin
            errors++;
            $display("FAIL illegal_reset: got %h want %h", out_image, ResetImage);
        end
        step();
        rst_ni = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_capture();
        test_drop_saturate();
        test_clear_window();
        test_back_to_back();
        test_escalation();
        test_fsm_error();
        test_reset_mid_clear();
        test_illegal_state();
        repeat (2) step();
        checks++;
        if (exp_valid_q.size() != 0 || exp_proc_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d valid and %0d processed outstanding, want 0 0",
                     exp_valid_q.size(), exp_proc_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_kmac_err_report
